// File: rtl/term_write_ctrl.sv
// Write-port sequencer for the character-cell terminal buffer.
// Turns print/newline/backspace/clear commands into cell writes and keeps the cursor.
module term_write_ctrl #(
  parameter int          COLS  = 80,
  parameter int          ROWS  = 60,
  parameter logic [5:0]  BLANK = 6'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_ctrl,
  input  logic [5:0] in_char,
  output logic [7:0] w_h_addr,
  output logic [7:0] w_v_addr,
  output logic [5:0] w_data,
  output logic       w_en,
  output logic [7:0] cur_h,
  output logic [7:0] cur_v,
  output logic       busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ROWCLR = 2'd1;
  localparam logic [1:0] S_CLEAR  = 2'd2;

  localparam logic [7:0] HMAX = 8'(COLS - 1);
  localparam logic [7:0] VMAX = 8'(ROWS - 1);

  localparam logic [1:0] C_PRINT = 2'b00;
  localparam logic [1:0] C_NL    = 2'b01;
  localparam logic [1:0] C_BS    = 2'b10;
  localparam logic [1:0] C_CLR   = 2'b11;

  logic [1:0] state;
  logic [7:0] clr_h;
  logic [7:0] clr_v;
  logic [7:0] next_v;
  logic       accept;

  assign in_ready = (state == S_IDLE);
  assign busy     = ~in_ready;
  assign accept   = in_ready & in_valid;

  // Row after the cursor row; output wraps to row 0 instead of scrolling.
  assign next_v = (cur_v == VMAX) ? 8'd0 : cur_v + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_CLEAR;
      clr_h    <= 8'd0;
      clr_v    <= 8'd0;
      cur_h    <= 8'd0;
      cur_v    <= 8'd0;
      w_en     <= 1'b0;
      w_h_addr <= 8'd0;
      w_v_addr <= 8'd0;
      w_data   <= BLANK;
    end else begin
      w_en <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            unique case (in_ctrl)
              C_PRINT: begin
                w_en     <= 1'b1;
                w_h_addr <= cur_h;
                w_v_addr <= cur_v;
                w_data   <= in_char;
                if (cur_h < HMAX) begin
                  cur_h <= cur_h + 8'd1;
                end else begin
                  cur_h <= 8'd0;
                  cur_v <= next_v;
                  clr_h <= 8'd0;
                  state <= S_ROWCLR;
                end
              end
              C_NL: begin
                cur_h <= 8'd0;
                cur_v <= next_v;
                clr_h <= 8'd0;
                state <= S_ROWCLR;
              end
              C_BS: begin
                if (cur_h != 8'd0) begin
                  cur_h    <= cur_h - 8'd1;
                  w_en     <= 1'b1;
                  w_h_addr <= cur_h - 8'd1;
                  w_v_addr <= cur_v;
                  w_data   <= BLANK;
                end else if (cur_v != 8'd0) begin
                  cur_h    <= HMAX;
                  cur_v    <= cur_v - 8'd1;
                  w_en     <= 1'b1;
                  w_h_addr <= HMAX;
                  w_v_addr <= cur_v - 8'd1;
                  w_data   <= BLANK;
                end
              end
              C_CLR: begin
                cur_h <= 8'd0;
                cur_v <= 8'd0;
                clr_h <= 8'd0;
                clr_v <= 8'd0;
                state <= S_CLEAR;
              end
              default: ;
            endcase
          end
        end
        S_ROWCLR: begin
          w_en     <= 1'b1;
          w_h_addr <= clr_h;
          w_v_addr <= cur_v;
          w_data   <= BLANK;
          if (clr_h == HMAX) begin
            clr_h <= 8'd0;
            state <= S_IDLE;
          end else begin
            clr_h <= clr_h + 8'd1;
          end
        end
        S_CLEAR: begin
          w_en     <= 1'b1;
          w_h_addr <= clr_h;
          w_v_addr <= clr_v;
          w_data   <= BLANK;
          if (clr_h == HMAX) begin
            clr_h <= 8'd0;
            if (clr_v == VMAX) begin
              clr_v <= 8'd0;
              state <= S_IDLE;
            end else begin
              clr_v <= clr_v + 8'd1;
            end
          end else begin
            clr_h <= clr_h + 8'd1;
          end
        end
        default: begin
          // Unreachable encoding: recover with a full clear.
          clr_h <= 8'd0;
          clr_v <= 8'd0;
          state <= S_CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_term_write_ctrl.sv
// Bench for term_write_ctrl on a 4x3 screen.
// Reference keeps a queue of cells still to be blanked plus a cursor.
module tb_term_write_ctrl;

  localparam int         COLS  = 4;
  localparam int         ROWS  = 3;
  localparam logic [5:0] BLANK = 6'd0;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_ctrl;
  logic [5:0] in_char;
  logic [7:0] w_h_addr;
  logic [7:0] w_v_addr;
  logic [5:0] w_data;
  logic       w_en;
  logic [7:0] cur_h;
  logic [7:0] cur_v;
  logic       busy;

  term_write_ctrl #(.COLS(COLS), .ROWS(ROWS), .BLANK(BLANK)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_char  (in_char),
    .w_h_addr (w_h_addr),
    .w_v_addr (w_v_addr),
    .w_data   (w_data),
    .w_en     (w_en),
    .cur_h    (cur_h),
    .cur_v    (cur_v),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference state: cells awaiting blanking, cursor, expected write.
  logic [15:0] q[$];
  int   mh, mv;
  bit   have_exp = 0;
  bit   e_wen, e_addr;
  int   e_h, e_v;
  logic [5:0] e_d;
  bit   acc;
  int   wcount = 0;

  function automatic int wrapv(int v);
    return (v == ROWS - 1) ? 0 : v + 1;
  endfunction

  task automatic push_row(input int v);
    for (int h = 0; h < COLS; h++) q.push_back(16'(v * 256 + h));
  endtask

  task automatic put(input int h, input int v, input logic [5:0] d);
    e_wen = 1; e_h = h; e_v = v; e_d = d; e_addr = 1;
  endtask

  task automatic model_edge();
    logic [15:0] c;
    acc = 0; e_wen = 0; e_addr = 0;
    have_exp = 1;
    if (rst) begin
      q.delete();
      for (int v = 0; v < ROWS; v++) push_row(v);
      mh = 0; mv = 0;
      e_h = 0; e_v = 0; e_d = BLANK; e_addr = 1;
    end else if (q.size() != 0) begin
      c = q.pop_front();
      put(int'(c[7:0]), int'(c[15:8]), BLANK);
    end else if (in_valid) begin
      acc = 1;
      case (in_ctrl)
        2'b00: begin
          put(mh, mv, in_char);
          if (mh < COLS - 1) mh++;
          else begin mh = 0; mv = wrapv(mv); push_row(mv); end
        end
        2'b01: begin mh = 0; mv = wrapv(mv); push_row(mv); end
        2'b10: begin
          if (mh > 0) begin mh--; put(mh, mv, BLANK); end
          else if (mv > 0) begin mv--; mh = COLS - 1; put(mh, mv, BLANK); end
        end
        default: begin
          mh = 0; mv = 0;
          for (int v = 0; v < ROWS; v++) push_row(v);
        end
      endcase
    end
  endtask

  task automatic compare_all();
    if (!have_exp) return;
    if (w_en === 1'b1) wcount++;
    check("in_ready", 16'(in_ready), 16'(q.size() == 0));
    check("busy", 16'(busy), 16'(q.size() != 0));
    check("w_en", 16'(w_en), 16'(e_wen));
    if (e_addr) begin
      check("w_h_addr", 16'(w_h_addr), 16'(e_h));
      check("w_v_addr", 16'(w_v_addr), 16'(e_v));
      check("w_data", 16'(w_data), 16'(e_d));
    end
    check("cur_h", 16'(cur_h), 16'(mh));
    check("cur_v", 16'(cur_v), 16'(mv));
  endtask

  task automatic step(input logic r, input logic v, input logic [1:0] c,
                      input logic [5:0] ch);
    @(negedge clk);
    compare_all();
    rst = r; in_valid = v; in_ctrl = c; in_char = ch;
    model_edge();
  endtask

  // Hold a command valid until the reference says it is taken.
  task automatic send(input logic [1:0] c, input logic [5:0] ch);
    int n = 0;
    do begin
      step(1'b0, 1'b1, c, ch);
      n++;
    end while (!acc && n < 2000);
    if (!acc) check("send_timeout", 16'(n), 16'(0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, 6'(i));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_ctrl = 2'b00; in_char = 6'd0;
    step(1'b1, 1'b0, 2'b00, 6'd0);
    step(1'b1, 1'b0, 2'b00, 6'd0);
    idle(13);
    check("reset_clear_writes", 16'(wcount), 16'(COLS * ROWS));

    send(2'b00, 6'd1);
    send(2'b00, 6'd2);
    idle(1);
    check("cursor_after_AB", 16'(cur_h), 16'd2);
    send(2'b00, 6'd3);
    send(2'b00, 6'd4);
    idle(6);
    check("wrap_row1", 16'(cur_v), 16'd1);

    send(2'b01, 6'd9);
    idle(6);
    send(2'b01, 6'd9);
    idle(6);
    check("nl_wrap_row0", 16'(cur_v), 16'd0);

    send(2'b10, 6'd0);
    send(2'b01, 6'd0);
    idle(6);
    send(2'b10, 6'd0);
    idle(1);
    check("bs_prev_row_h", 16'(cur_h), 16'(COLS - 1));
    send(2'b01, 6'd0);
    idle(6);
    send(2'b00, 6'd5);
    send(2'b00, 6'd6);
    send(2'b10, 6'd0);
    idle(2);

    send(2'b11, 6'd0);
    idle(5);
    step(1'b1, 1'b0, 2'b00, 6'd0);
    send(2'b00, 6'd7);
    idle(2);

    for (int i = 0; i < 600; i++) begin
      int k;
      k = int'($urandom_range(0, 15));
      if ($urandom_range(0, 199) == 0)
        step(1'b1, 1'b0, 2'b00, 6'd0);
      else if (k < 9)
        step(1'b0, 1'($urandom_range(0, 3) != 0), 2'b00, 6'($urandom));
      else if (k < 12)
        step(1'b0, 1'b1, 2'b01, 6'($urandom));
      else if (k < 15)
        step(1'b0, 1'b1, 2'b10, 6'($urandom));
      else
        step(1'b0, 1'($urandom_range(0, 3) == 0), 2'b11, 6'($urandom));
    end
    @(negedge clk);
    compare_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
